// File: rtl/cpu_trace_tx_if.sv
// Byte-stream link between the trace serializer and its sink (UART or host bridge).
// A byte moves when tx_valid && tx_ready at a rising clock edge.
interface cpu_trace_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/cpu_trace_tx.sv
// CPU trace transmitter: captures probe records into a FIFO and streams each as a framed
// byte sequence. Define TRACE_CHECKSUM_EN to append an XOR checksum byte to every frame.
module cpu_trace_tx #(
  parameter int unsigned DEPTH     = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trace_valid,
  input  logic [15:0]       pc,
  input  logic [15:0]       ir,
  input  logic [15:0]       alu_out,
  input  logic [3:0]        alu_status,
  input  logic              reg_write,
  cpu_trace_tx_if.master    tx,
  output logic              overflow,
  output logic [7:0]        drop_cnt,
  output logic              busy
);

  localparam int AW    = $clog2(DEPTH);
  localparam int REC_W = 53;
`ifdef TRACE_CHECKSUM_EN
  localparam logic [3:0] LAST = 4'd8;
`else
  localparam logic [3:0] LAST = 4'd7;
`endif

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state_q, state_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [REC_W-1:0] mem_q [DEPTH];
  logic [REC_W-1:0] wr_rec_d;
  logic [REC_W-1:0] shift_q, shift_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic             full, empty, push, drop, pop, hs, last_byte;
  logic [AW:0]      count;

`ifdef TRACE_CHECKSUM_EN
  function automatic logic [7:0] checksum(input logic [REC_W-1:0] rec);
    checksum = rec[52:45] ^ rec[44:37] ^ rec[36:29] ^ rec[28:21] ^
               rec[20:13] ^ rec[12:5]  ^ {rec[4:1], 3'b000, rec[0]};
  endfunction
`endif

  // Record layout: {pc[52:37], ir[36:21], alu_out[20:5], alu_status[4:1], reg_write[0]}
  function automatic logic [7:0] frame_byte(input logic [REC_W-1:0] rec, input logic [3:0] i);
    case (i)
      4'd0:    frame_byte = SYNC_BYTE;
      4'd1:    frame_byte = rec[52:45];
      4'd2:    frame_byte = rec[44:37];
      4'd3:    frame_byte = rec[36:29];
      4'd4:    frame_byte = rec[28:21];
      4'd5:    frame_byte = rec[20:13];
      4'd6:    frame_byte = rec[12:5];
      4'd7:    frame_byte = {rec[4:1], 3'b000, rec[0]};
`ifdef TRACE_CHECKSUM_EN
      default: frame_byte = checksum(rec);
`else
      default: frame_byte = 8'h00;
`endif
    endcase
  endfunction

  always_comb begin
    count     = wr_ptr_q - rd_ptr_q;
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // Fullness is judged before the edge, so a same-edge pop never rescues a push.
    push      = trace_valid && !full;
    drop      = trace_valid && full;
    hs        = (state_q == SEND) && tx.tx_ready;
    last_byte = (idx_q == LAST);
    pop       = !empty && ((state_q == IDLE) || (hs && last_byte));
    wr_rec_d  = {pc, ir, alu_out, alu_status, reg_write};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty) state_d = SEND;
      SEND:    if (hs && last_byte && empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx.tx_valid = (state_q == SEND);
    tx.tx_data  = tx_data_q;
    busy        = (count != '0) || (state_q == SEND);
    overflow    = overflow_q;
    drop_cnt    = drop_cnt_q;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
    overflow_d = overflow_q | drop;
    drop_cnt_d = (drop && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    // A pop always starts a fresh frame; otherwise advance only on an accepted byte.
    if (pop) begin
      shift_d   = mem_q[rd_ptr_q[AW-1:0]];
      idx_d     = 4'd0;
      tx_data_d = SYNC_BYTE;
    end else if (hs && !last_byte) begin
      idx_d     = idx_q + 4'd1;
      tx_data_d = frame_byte(shift_q, idx_q + 4'd1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Record storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_rec_d;
    shift_q <= shift_d;
  end

endmodule

// File: tb/tb_cpu_trace_tx.sv
// Self-checking bench for cpu_trace_tx: byte scoreboard, table-driven records and
// hand-written overflow, back-to-back, saturation and mid-frame reset sequences.
module tb_cpu_trace_tx;
  localparam int DEPTH = 8;
`ifdef TRACE_CHECKSUM_EN
  localparam int FLEN = 9;
`else
  localparam int FLEN = 8;
`endif

  typedef struct {
    logic [15:0] pc;
    logic [15:0] ir;
    logic [15:0] alu;
    logic [3:0]  st;
    logic        rw;
    int          rmode;
    logic [63:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trace_valid = 1'b0;
  logic [15:0] pc = '0, ir = '0, alu = '0;
  logic [3:0]  st = '0;
  logic        rw = 1'b0;
  logic        overflow, busy;
  logic [7:0]  drop_cnt;

  cpu_trace_tx_if tx_if ();

  cpu_trace_tx #(.DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .trace_valid(trace_valid),
    .pc(pc), .ir(ir), .alu_out(alu), .alu_status(st), .reg_write(rw),
    .tx(tx_if), .overflow(overflow), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q [$];
  int         hs_cnt = 0;
  int         vrun = 0, last_run = 0;
  logic       last_busy = 1'b1;
  int         rmode = 0;
  vec_t       vecs [4];
  int         exp_drops;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_exp(input logic [15:0] p, input logic [15:0] i,
                                         input logic [15:0] a, input logic [3:0] s, input logic r);
    mk_exp = {8'hA5, p, i, a, s, 3'b000, r};
  endfunction

  task automatic push_exp(input logic [63:0] e);
    for (int k = 7; k >= 0; k--) exp_q.push_back(e[k*8 +: 8]);
`ifdef TRACE_CHECKSUM_EN
    begin
      logic [7:0] cs;
      cs = 8'h00;
      for (int k = 6; k >= 0; k--) cs ^= e[k*8 +: 8];
      exp_q.push_back(cs);
    end
`endif
  endtask

  // Called at posedge+1; drives one trace cycle and returns at the next posedge+1.
  task automatic push_rec(input logic [15:0] p, input logic [15:0] i, input logic [15:0] a,
                          input logic [3:0] s, input logic r, input bit kept);
    pc = p; ir = i; alu = a; st = s; rw = r; trace_valid = 1'b1;
    if (kept) push_exp(mk_exp(p, i, a, s, r));
    @(posedge clk); #1;
    trace_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (n >= budget) begin
      n_err++;
      $display("FAIL %s_timeout: %0d bytes still expected, busy=%0b", name, exp_q.size(), busy);
    end
    @(posedge clk); #1;
  endtask

  // Ready driver: 0 = always ready, 1 = repeating 1,0,0,1, 2 = never ready.
  initial begin
    int cyc;
    cyc = 0;
    tx_if.tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       tx_if.tx_ready = 1'b1;
        1:       tx_if.tx_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: tx_if.tx_ready = 1'b0;
      endcase
      cyc++;
    end
  end

  // Monitor: scoreboard pop on each accepted byte, hold check while stalled.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic [7:0] e;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        vrun = 0;
      end else begin
        if (prev_stall) check("stall_hold", {23'd0, tx_if.tx_valid, tx_if.tx_data}, {23'd0, 1'b1, prev_data});
        if (tx_if.tx_valid && tx_if.tx_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_byte: got %0h expected none", tx_if.tx_data);
          end else begin
            e = exp_q.pop_front();
            check("stream_byte", {24'd0, tx_if.tx_data}, {24'd0, e});
          end
        end
        if (tx_if.tx_valid) vrun++;
        else if (vrun != 0) begin
          last_run  = vrun;
          last_busy = busy;
          vrun = 0;
        end
        prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
        prev_data  = tx_if.tx_data;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    vecs[0] = '{16'h0004, 16'h1234, 16'hBEEF, 4'h9, 1'b1, 0, 64'hA500041234BEEF91};
    vecs[1] = '{16'hFFFF, 16'h0000, 16'h8001, 4'hF, 1'b0, 1, 64'hA5FFFF00008001F0};
    vecs[2] = '{16'h1357, 16'h2468, 16'h0000, 4'h0, 1'b1, 1, 64'hA513572468000001};
    vecs[3] = '{16'hA5A5, 16'h5A5A, 16'h00FF, 4'h6, 1'b0, 0, 64'hA5A5A55A5A00FF60};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", {31'd0, tx_if.tx_valid}, 32'd0);
    check("rst_tx_data",  {24'd0, tx_if.tx_data}, 32'd0);
    check("rst_busy",     {31'd0, busy}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Single record with latency check
    pc = vecs[0].pc; ir = vecs[0].ir; alu = vecs[0].alu; st = vecs[0].st; rw = vecs[0].rw;
    trace_valid = 1'b1;
    push_exp(vecs[0].exp);
    @(posedge clk); #1;
    trace_valid = 1'b0;
    check("lat_e0_valid", {31'd0, tx_if.tx_valid}, 32'd0);
    @(posedge clk); #1;
    check("lat_e1_valid", {31'd0, tx_if.tx_valid}, 32'd1);
    check("lat_e1_sync",  {24'd0, tx_if.tx_data}, 32'hA5);
    wait_drain("single", 100);
    check("single_run_len", last_run, FLEN);

    // Table of records, some under 1,0,0,1 backpressure
    for (int v = 0; v < 4; v++) begin
      rmode = vecs[v].rmode;
      @(posedge clk); #1;
      pc = vecs[v].pc; ir = vecs[v].ir; alu = vecs[v].alu; st = vecs[v].st; rw = vecs[v].rw;
      trace_valid = 1'b1;
      push_exp(vecs[v].exp);
      @(posedge clk); #1;
      trace_valid = 1'b0;
      wait_drain("table", 200);
      check("table_no_drop", {31'd0, overflow}, 32'd0);
    end

    // Overflow: the first record moves straight into the serializer, so DEPTH+1 survive.
    rmode = 2;
    @(posedge clk); #1;
    base = hs_cnt;
    for (int i = 0; i < 12; i++)
      push_rec(16'h1000 + 16'(i), 16'hF0F0 ^ 16'(i * 7), 16'(i * 3), 4'(i), i[0], i < DEPTH + 1);
    exp_drops = 12 - (DEPTH + 1);
    check("ovf_overflow", {31'd0, overflow}, 32'd1);
    check("ovf_drop_cnt", {24'd0, drop_cnt}, exp_drops);
    check("ovf_busy",     {31'd0, busy}, 32'd1);
    check("ovf_no_bytes", hs_cnt - base, 0);
    rmode = 0;
    wait_drain("ovf_drain", 400);
    check("ovf_frames", hs_cnt - base, (DEPTH + 1) * FLEN);

    // Back-to-back frames with continuous ready
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++)
      push_rec(16'h2000 + 16'(i), 16'h3000 - 16'(i), 16'hC000 | 16'(i), 4'hA - 4'(i), ~i[0], 1'b1);
    wait_drain("b2b", 200);
    check("b2b_run_len",   last_run, 3 * FLEN);
    check("b2b_busy_fall", {31'd0, last_busy}, 32'd0);

    // Drop counter saturation
    rmode = 2;
    @(posedge clk); #1;
    pc = 16'h7777; ir = 16'h8888; alu = 16'h9999; st = 4'h3; rw = 1'b1;
    trace_valid = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("sat_mid", {24'd0, drop_cnt}, exp_drops + 100 - (DEPTH + 1));
    repeat (220) @(posedge clk);
    #1;
    check("sat_hold", {24'd0, drop_cnt}, 32'hFF);
    repeat (5) @(posedge clk);
    #1;
    trace_valid = 1'b0;
    check("sat_still", {24'd0, drop_cnt}, 32'hFF);
    rst = 1'b1;
    #1;
    check("sat_rst_drop",  {24'd0, drop_cnt}, 32'd0);
    check("sat_rst_ovf",   {31'd0, overflow}, 32'd0);
    check("sat_rst_busy",  {31'd0, busy}, 32'd0);
    check("sat_rst_data",  {24'd0, tx_if.tx_data}, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    rmode = 0;
    @(posedge clk); #1;

    // Reset mid-frame after three accepted bytes
    base = hs_cnt;
    push_rec(16'h4321, 16'h8765, 16'hCAFE, 4'h5, 1'b0, 1'b1);
    n = 0;
    while ((hs_cnt - base) < 3 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid_reached", (hs_cnt - base) >= 3, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, tx_if.tx_valid}, 32'd0);
    check("mid_rst_busy",  {31'd0, busy}, 32'd0);
    check("mid_rst_drop",  {24'd0, drop_cnt}, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    base = hs_cnt;
    push_rec(vecs[3].pc, vecs[3].ir, vecs[3].alu, vecs[3].st, vecs[3].rw, 1'b1);
    wait_drain("post_rst", 100);
    check("post_rst_bytes", hs_cnt - base, FLEN);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
